lcd_char_driver: RTL and testbench
==================================

Name: lcd_char_driver

Overview:
- Write-only driver for an HD44780-compatible 16x2 character LCD in 8-bit bus mode.
- Initialises the panel after reset, then continuously refreshes both lines from 32 parallel 8-bit ASCII inputs.
- The surrounding top level owns the character registers; this block only reads them.

Parameters:
- T_POWERUP, 2000000: cycles to wait after reset before the first command (20 ms at 100 MHz).
- T_SETUP, 4: cycles lcd_rs/lcd_data are stable with lcd_e low before the E pulse.
- T_PULSE, 24: cycles lcd_e is held high.
- T_HOLD, 4: cycles lcd_e is low with lcd_rs/lcd_data held after the pulse.
- T_INIT, 410000: wait after each of the first three function-set commands.
- T_CMD, 4000: wait after an ordinary command or character write (40 us).
- T_CLEAR, 164000: wait after the clear-display command.

Ports:
- board_clk input 1: system clock (100 MHz nominal).
- Reset input 1: asynchronous, active-high reset.
- lcd_data output 8: LCD data bus.
- lcd_e output 1: LCD enable strobe.
- lcd_rs output 1: register select; 0 = command, 1 = character data.
- lcd_rw output 1: read/write; tied to 0 (write only).
- data_f1..data_f16 input 8 each: ASCII characters for line 1, columns 0..15.
- data_s1..data_s16 input 8 each: ASCII characters for line 2, columns 0..15.

Behaviour:
- Clock and reset: clock board_clk; reset Reset, asynchronous, active-high.
- Reset values: lcd_e=0, lcd_rs=0, lcd_data=8'h00, lcd_rw=0 at all times. The sequencer returns to POWERUP and all counters clear.
- POWERUP: outputs idle for T_POWERUP cycles, then the init sequence starts.
- Write transaction: every command or character is one transaction of four phases.
  - SETUP: lcd_rs and lcd_data driven, lcd_e=0, for T_SETUP cycles.
  - PULSE: lcd_e=1, for T_PULSE cycles.
  - HOLD: lcd_e=0, rs/data unchanged, for T_HOLD cycles.
  - WAIT: lcd_e=0, rs/data unchanged, for the wait count of that transaction.
- The next transaction's SETUP starts on the cycle after WAIT ends. lcd_e is high for exactly T_PULSE consecutive cycles per transaction and never otherwise.
- Init sequence (all rs=0), in order:
  - 8'h38 with T_INIT wait, issued three times.
  - 8'h38 with T_CMD wait.
  - 8'h06 (entry mode, increment) with T_CMD wait.
  - 8'h0C (display on, cursor off) with T_CMD wait.
  - 8'h01 (clear) with T_CLEAR wait.
- Refresh loop, repeated forever:
  - 8'h80 (rs=0).
  - data_f1..data_f16 (rs=1).
  - 8'hC0 (rs=0).
  - data_s1..data_s16 (rs=1).
  - Then back to 8'h80.
  - Every refresh transaction uses the T_CMD wait.
  - Init is never repeated except after Reset.
- Sampling: each character input is sampled into lcd_data on the first cycle of its SETUP phase. Later changes to that input take effect on the next refresh pass, with no tearing within one transaction.
- Loop period: 34 transactions x (T_SETUP+T_PULSE+T_HOLD+T_CMD) cycles.
- Counters must be wide enough for the largest parameter (at least 22 bits at defaults). Terminal counts are exact, with no off-by-one: a phase of N cycles holds its outputs for exactly N clock cycles.
- Reset mid-transaction (including while lcd_e=1): lcd_e drops to 0 asynchronously and the sequence restarts at POWERUP. No partial write is resumed.

Test Plan:
- Use reduced parameters: T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_HOLD=2, T_INIT=5, T_CMD=4, T_CLEAR=8.
- Reset released -> lcd_e=0, lcd_data=8'h00, lcd_rs=0 for exactly 10 cycles; the first SETUP then drives 8'h38 with rs=0.
- Init capture on each lcd_e rising edge -> sequence {38,38,38,38,06,0C,01} with rs=0; each lcd_e high exactly 3 cycles; gap after 8'h01 is 2+8 cycles before the next SETUP.
- data_f1..f16="HELLO WORLD     ", data_s1..s16="MORSE CODE TEST " -> after init, strobes show 80, the 16 line-1 chars (rs=1), C0, the 16 line-2 chars; the loop repeats with period 34x11 cycles.
- Change data_f3 from "L" to "X" during its own PULSE phase -> the current strobe still shows "L"; the next pass shows "X".
- Assert Reset while lcd_e=1 during the refresh loop -> lcd_e=0 in the same cycle; after release, a full POWERUP wait plus the init sequence occurs again.
- Check lcd_rw over the whole run -> constant 0; lcd_rs/lcd_data never change while lcd_e=1.

Source files
------------

// File: rtl/lcd_char_driver.sv
// Write-only HD44780 16x2 driver in 8-bit mode: power-up wait, fixed init
// sequence, then an endless refresh of both lines from the character inputs.
module lcd_char_driver #(
  parameter int T_POWERUP = 2000000,
  parameter int T_SETUP   = 4,
  parameter int T_PULSE   = 24,
  parameter int T_HOLD    = 4,
  parameter int T_INIT    = 410000,
  parameter int T_CMD     = 4000,
  parameter int T_CLEAR   = 164000
) (
  input  logic       board_clk,
  input  logic       Reset,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [7:0] data_f1,  input logic [7:0] data_f2,  input logic [7:0] data_f3,
  input  logic [7:0] data_f4,  input logic [7:0] data_f5,  input logic [7:0] data_f6,
  input  logic [7:0] data_f7,  input logic [7:0] data_f8,  input logic [7:0] data_f9,
  input  logic [7:0] data_f10, input logic [7:0] data_f11, input logic [7:0] data_f12,
  input  logic [7:0] data_f13, input logic [7:0] data_f14, input logic [7:0] data_f15,
  input  logic [7:0] data_f16,
  input  logic [7:0] data_s1,  input logic [7:0] data_s2,  input logic [7:0] data_s3,
  input  logic [7:0] data_s4,  input logic [7:0] data_s5,  input logic [7:0] data_s6,
  input  logic [7:0] data_s7,  input logic [7:0] data_s8,  input logic [7:0] data_s9,
  input  logic [7:0] data_s10, input logic [7:0] data_s11, input logic [7:0] data_s12,
  input  logic [7:0] data_s13, input logic [7:0] data_s14, input logic [7:0] data_s15,
  input  logic [7:0] data_s16
);

  localparam int M1 = (T_POWERUP > T_INIT) ? T_POWERUP : T_INIT;
  localparam int M2 = (M1 > T_CLEAR) ? M1 : T_CLEAR;
  localparam int M3 = (M2 > T_CMD) ? M2 : T_CMD;
  localparam int M4 = (M3 > T_PULSE) ? M3 : T_PULSE;
  localparam int M5 = (M4 > T_SETUP) ? M4 : T_SETUP;
  localparam int M6 = (M5 > T_HOLD) ? M5 : T_HOLD;
  localparam int CNT_W = $clog2(M6 + 1) + 1;

  // Steps 0..6 are the init commands, 7..40 one refresh pass.
  localparam logic [5:0] STEP_LOOP = 6'd7;
  localparam logic [5:0] STEP_LAST = 6'd40;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next, limit;
  logic [5:0]         step, step_next, ref_idx;
  logic [3:0]         col1, col2;
  logic               phase_end, load, sel_rs;
  logic [7:0]         sel_data;
  logic [7:0]         line1 [16];
  logic [7:0]         line2 [16];

  assign line1 = '{data_f1, data_f2, data_f3, data_f4, data_f5, data_f6, data_f7, data_f8,
                   data_f9, data_f10, data_f11, data_f12, data_f13, data_f14, data_f15, data_f16};
  assign line2 = '{data_s1, data_s2, data_s3, data_s4, data_s5, data_s6, data_s7, data_s8,
                   data_s9, data_s10, data_s11, data_s12, data_s13, data_s14, data_s15, data_s16};

  assign lcd_rw = 1'b0;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_POWERUP;
      cnt      <= '0;
      step     <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      step  <= step_next;
      lcd_e <= (state_next == S_PULSE);
      // Bus values are captured only at SETUP entry so a transaction never tears.
      if (load) begin
        lcd_rs   <= sel_rs;
        lcd_data <= sel_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    step_next  = step;
    limit      = '0;

    unique case (state)
      S_POWERUP: limit = CNT_W'(T_POWERUP - 1);
      S_SETUP:   limit = CNT_W'(T_SETUP - 1);
      S_PULSE:   limit = CNT_W'(T_PULSE - 1);
      S_HOLD:    limit = CNT_W'(T_HOLD - 1);
      S_WAIT: begin
        if (step < 6'd3)       limit = CNT_W'(T_INIT - 1);
        else if (step == 6'd6) limit = CNT_W'(T_CLEAR - 1);
        else                   limit = CNT_W'(T_CMD - 1);
      end
      default:   limit = '0;
    endcase

    phase_end = (cnt == limit);
    load      = phase_end && (state == S_POWERUP || state == S_WAIT);

    if (phase_end) begin
      cnt_next = '0;
      unique case (state)
        S_POWERUP: state_next = S_SETUP;
        S_SETUP:   state_next = S_PULSE;
        S_PULSE:   state_next = S_HOLD;
        S_HOLD:    state_next = S_WAIT;
        S_WAIT: begin
          state_next = S_SETUP;
          step_next  = (step == STEP_LAST) ? STEP_LOOP : step + 6'd1;
        end
        default:   state_next = S_POWERUP;
      endcase
    end

    // Byte and register select for the transaction about to start.
    ref_idx  = step_next - STEP_LOOP;
    col1     = ref_idx[3:0] - 4'd1;
    col2     = ref_idx[3:0] - 4'd2;
    sel_rs   = 1'b0;
    sel_data = 8'h38;
    if (step_next < STEP_LOOP) begin
      unique case (step_next)
        6'd4:    sel_data = 8'h06;
        6'd5:    sel_data = 8'h0C;
        6'd6:    sel_data = 8'h01;
        default: sel_data = 8'h38;
      endcase
    end else if (ref_idx == 6'd0) begin
      sel_data = 8'h80;
    end else if (ref_idx < 6'd17) begin
      sel_rs   = 1'b1;
      sel_data = line1[col1];
    end else if (ref_idx == 6'd17) begin
      sel_data = 8'hC0;
    end else begin
      sel_rs   = 1'b1;
      sel_data = line2[col2];
    end
  end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with shortened timing: strobe table of
// expected {rs, data, rise-to-rise gap}, plus reset and mid-pulse corner cases.
module tb_lcd_char_driver;

  localparam int TP = 10, TS = 2, TPU = 3, TH = 2, TI = 5, TC = 4, TCL = 8;

  logic       board_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] lcd_data;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] f [16];
  logic [7:0] s [16];

  lcd_char_driver #(
    .T_POWERUP(TP), .T_SETUP(TS), .T_PULSE(TPU), .T_HOLD(TH),
    .T_INIT(TI), .T_CMD(TC), .T_CLEAR(TCL)
  ) dut (
    .board_clk(board_clk), .Reset(Reset),
    .lcd_data(lcd_data), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .data_f1(f[0]),   .data_f2(f[1]),   .data_f3(f[2]),   .data_f4(f[3]),
    .data_f5(f[4]),   .data_f6(f[5]),   .data_f7(f[6]),   .data_f8(f[7]),
    .data_f9(f[8]),   .data_f10(f[9]),  .data_f11(f[10]), .data_f12(f[11]),
    .data_f13(f[12]), .data_f14(f[13]), .data_f15(f[14]), .data_f16(f[15]),
    .data_s1(s[0]),   .data_s2(s[1]),   .data_s3(s[2]),   .data_s4(s[3]),
    .data_s5(s[4]),   .data_s6(s[5]),   .data_s7(s[6]),   .data_s8(s[7]),
    .data_s9(s[8]),   .data_s10(s[9]),  .data_s11(s[10]), .data_s12(s[11]),
    .data_s13(s[12]), .data_s14(s[13]), .data_s15(s[14]), .data_s16(s[15])
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
    bit         poke;
  } vec_t;

  vec_t       tbl [75];
  int         rise_at [75];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rw_bad = 0;
  int         stab_bad = 0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Whole-run monitor: rw tied low, bus frozen whenever E is high.
  always @(negedge board_clk) begin
    cyc <= cyc + 1;
    if (lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
    if (lcd_e === 1'b1 && (lcd_data !== prev_data || lcd_rs !== prev_rs))
      stab_bad <= stab_bad + 1;
    prev_data <= lcd_data;
    prev_rs   <= lcd_rs;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge board_clk);
      if (lcd_e === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic powerup_check();
    int bad = 0;
    for (int k = 1; k < TP; k++) begin
      @(negedge board_clk);
      if (lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00) bad++;
    end
    chk("powerup_idle", bad, 0);
    @(negedge board_clk);
    chk("first_setup_data", {24'h0, lcd_data}, 32'h38);
    chk("first_setup_rs", {31'h0, lcd_rs}, 0);
    chk("first_setup_e", {31'h0, lcd_e}, 0);
  endtask

  task automatic run_entries(input int lo, input int hi, input int t0);
    int prev = t0;
    int w;
    bit ok;
    for (int i = lo; i <= hi; i++) begin
      wait_rise(ok);
      if (!ok) begin
        chk($sformatf("rise_timeout[%0d]", i), 0, 1);
        return;
      end
      rise_at[i] = cyc;
      chk($sformatf("strobe_data[%0d]", i), {24'h0, lcd_data}, {24'h0, tbl[i].data});
      chk($sformatf("strobe_rs[%0d]", i), {31'h0, lcd_rs}, {31'h0, tbl[i].rs});
      chk($sformatf("strobe_gap[%0d]", i), cyc - prev, tbl[i].gap);
      prev = cyc;
      if (tbl[i].poke) f[2] = "X";
      w = 1;
      for (int k = 0; k < 50; k++) begin
        @(negedge board_clk);
        if (lcd_e !== 1'b1) break;
        w++;
      end
      chk($sformatf("pulse_width[%0d]", i), w, TPU);
      if (tbl[i].poke) chk("poke_hold_data", {24'h0, lcd_data}, 32'h4C);
    end
  endtask

  initial begin
    string      l1 = "HELLO WORLD     ";
    string      l2 = "MORSE CODE TEST ";
    logic [7:0] init_d [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h06, 8'h0C, 8'h01};
    int         init_g [7] = '{12, 12, 12, 12, 11, 11, 11};
    int         t0;
    int         base;
    bit         ok;

    for (int i = 0; i < 16; i++) begin
      f[i] = l1[i];
      s[i] = l2[i];
    end
    for (int i = 0; i < 7; i++) begin
      tbl[i].rs = 1'b0; tbl[i].data = init_d[i]; tbl[i].gap = init_g[i]; tbl[i].poke = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      base = 7 + 34 * p;
      for (int r = 0; r < 34; r++) begin
        tbl[base+r].poke = (p == 0 && r == 3);
        tbl[base+r].gap  = (p == 0 && r == 0) ? 15 : 11;
        if (r == 0) begin
          tbl[base+r].rs = 1'b0; tbl[base+r].data = 8'h80;
        end else if (r <= 16) begin
          tbl[base+r].rs = 1'b1; tbl[base+r].data = l1[r-1];
        end else if (r == 17) begin
          tbl[base+r].rs = 1'b0; tbl[base+r].data = 8'hC0;
        end else begin
          tbl[base+r].rs = 1'b1; tbl[base+r].data = l2[r-18];
        end
      end
    end
    tbl[44].data = "X";

    repeat (3) @(negedge board_clk);
    chk("reset_e", {31'h0, lcd_e}, 0);
    chk("reset_rs", {31'h0, lcd_rs}, 0);
    chk("reset_data", {24'h0, lcd_data}, 0);
    chk("reset_rw", {31'h0, lcd_rw}, 0);

    @(negedge board_clk);
    Reset = 1'b0;
    t0 = cyc;
    powerup_check();
    run_entries(0, 74, t0);
    chk("loop_period", rise_at[41] - rise_at[7], 34 * (TS + TPU + TH + TC));

    // Reset while E is high during refresh.
    wait_rise(ok);
    chk("refresh_rise_before_reset", {31'h0, ok}, 1);
    Reset = 1'b1;
    #1;
    chk("async_reset_e", {31'h0, lcd_e}, 0);
    chk("async_reset_data", {24'h0, lcd_data}, 0);
    repeat (3) @(negedge board_clk);
    chk("held_reset_e", {31'h0, lcd_e}, 0);
    @(negedge board_clk);
    Reset = 1'b0;
    t0 = cyc;
    powerup_check();
    run_entries(0, 7, t0);

    chk("rw_always_low", rw_bad, 0);
    chk("bus_stable_while_e", stab_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
